// File: rtl/core101_pipe_pkg.sv
// Shared types for the Core101 elastic pipeline stages: stage state encoding
// and occupancy constants.
package core101_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_BUSY  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  function automatic logic [1:0] occupancy_of(input state_e s);
    case (s)
      BUSY:    return OCC_BUSY;
      FULL:    return OCC_FULL;
      default: return OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on each edge with inc_in high and sticks
// at all-ones. Cleared only by the asynchronous reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             inc_in,
  output logic [WIDTH-1:0] count_out
);

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      count_out <= '0;
    end else if (inc_in && (count_out != '1)) begin
      count_out <= count_out + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register with a one-entry skid buffer and synchronous flush.
// Define PIPE_SKID_STALL_CNT_EN to build the saturating downstream-stall counter.
module pipe_skid_reg
  import core101_pipe_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clock_in,
  input  logic                       reset_in,
  input  logic                       flush_in,
  input  logic                       up_valid_in,
  input  logic [DATA_WIDTH-1:0]      up_data_in,
  output logic                       up_ready_out,
  output logic                       dn_valid_out,
  output logic [DATA_WIDTH-1:0]      dn_data_out,
  input  logic                       dn_ready_in,
  output logic [1:0]                 occupancy_out,
  output logic [STALL_CNT_WIDTH-1:0] stall_count_out
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, skid_q;
  logic                  up_xfer, dn_xfer;
  logic                  load_main_up, load_main_skid, load_skid;

  // Handshake outputs decode only the state register, so ready never sees dn_ready_in.
  assign up_ready_out  = (state_q != FULL);
  assign dn_valid_out  = (state_q != EMPTY);
  assign dn_data_out   = main_q;
  assign occupancy_out = occupancy_of(state_q);

  assign up_xfer = up_valid_in & up_ready_out;
  assign dn_xfer = dn_valid_out & dn_ready_in;

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that leaves one unassigned infers a latch.
    state_d        = state_q;
    load_main_up   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (up_xfer) begin
          load_main_up = 1'b1;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (up_xfer && dn_xfer) begin
          load_main_up = 1'b1;
        end else if (up_xfer) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (dn_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (dn_xfer) begin
          load_main_skid = 1'b1;
          state_d        = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins: drop the incoming beat and leave the data registers untouched.
    if (flush_in) begin
      state_d        = EMPTY;
      load_main_up   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (reset_in) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    // NOTE: payload registers are reset on purpose: dn_data_out must read 0 while reset is high.
    if (reset_in) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_up)        main_q <= up_data_in;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= up_data_in;
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  sat_counter #(
    .WIDTH (STALL_CNT_WIDTH)
  ) u_stall_cnt (
    .clock_in  (clock_in),
    .reset_in  (reset_in),
    .inc_in    (dn_valid_out & ~dn_ready_in),
    .count_out (stall_count_out)
  );
`else
  assign stall_count_out = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: streaming, stall/skid absorb, flush, async
// reset mid-operation, and counter saturation on a 143-bit instance.
module tb_pipe_skid_reg;

`ifdef PIPE_SKID_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  logic        up_valid = 1'b0;
  logic [31:0] up_data  = '0;
  logic        up_ready;
  logic        dn_valid;
  logic [31:0] dn_data;
  logic        dn_ready = 1'b0;
  logic [1:0]  occ;
  logic [15:0] stall_cnt;

  logic         w_up_valid = 1'b0;
  logic [142:0] w_up_data  = '0;
  logic         w_up_ready;
  logic         w_dn_valid;
  logic [142:0] w_dn_data;
  logic         w_dn_ready = 1'b0;
  logic [1:0]   w_occ;
  logic [1:0]   w_stall_cnt;
  logic [142:0] w_pat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_WIDTH(32), .STALL_CNT_WIDTH(16)) u_dut (
    .clock_in        (clk),
    .reset_in        (rst),
    .flush_in        (flush),
    .up_valid_in     (up_valid),
    .up_data_in      (up_data),
    .up_ready_out    (up_ready),
    .dn_valid_out    (dn_valid),
    .dn_data_out     (dn_data),
    .dn_ready_in     (dn_ready),
    .occupancy_out   (occ),
    .stall_count_out (stall_cnt)
  );

  pipe_skid_reg #(.DATA_WIDTH(143), .STALL_CNT_WIDTH(2)) u_wide (
    .clock_in        (clk),
    .reset_in        (rst),
    .flush_in        (1'b0),
    .up_valid_in     (w_up_valid),
    .up_data_in      (w_up_data),
    .up_ready_out    (w_up_ready),
    .dn_valid_out    (w_dn_valid),
    .dn_data_out     (w_dn_data),
    .dn_ready_in     (w_dn_ready),
    .occupancy_out   (w_occ),
    .stall_count_out (w_stall_cnt)
  );

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input logic v, input logic [31:0] d,
                            input logic r, input logic [1:0] o);
    check({tag, ".valid"}, 192'(dn_valid), 192'(v));
    if (v) check({tag, ".data"}, 192'(dn_data), 192'(d));
    check({tag, ".ready"}, 192'(up_ready), 192'(r));
    check({tag, ".occ"}, 192'(occ), 192'(o));
  endtask

  initial begin
    // Reset state, observed while reset is still held.
    @(posedge clk);
    #1;
    check("rst.valid", 192'(dn_valid), 192'(1'b0));
    check("rst.data", 192'(dn_data), 192'(32'd0));
    check("rst.ready", 192'(up_ready), 192'(1'b1));
    check("rst.occ", 192'(occ), 192'(2'd0));
    check("rst.stall", 192'(stall_cnt), 192'(16'd0));
    #4 rst = 1'b0;

    // Streaming 1..4 with downstream always ready.
    up_valid = 1'b1;
    dn_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      up_data = 32'(k);
      tick();
      check_main($sformatf("stream%0d", k), 1'b1, 32'(k), 1'b1, 2'd1);
    end

    // Downstream stalls for 3 edges; beat 5 lands in skid, then ready drops.
    up_data  = 32'd5;
    dn_ready = 1'b0;
    tick();
    check_main("stall1", 1'b1, 32'd4, 1'b0, 2'd2);
    up_data = 32'd6;
    tick();
    check_main("stall2", 1'b1, 32'd4, 1'b0, 2'd2);
    tick();
    check_main("stall3", 1'b1, 32'd4, 1'b0, 2'd2);
    check("stall.cnt3", 192'(stall_cnt), 192'(CNT_EN ? 16'd3 : 16'd0));

    // Resume: 5 from skid, then 6 and 7 in order.
    dn_ready = 1'b1;
    tick();
    check_main("resume5", 1'b1, 32'd5, 1'b1, 2'd1);
    tick();
    check_main("resume6", 1'b1, 32'd6, 1'b1, 2'd1);
    up_data = 32'd7;
    tick();
    check_main("resume7", 1'b1, 32'd7, 1'b1, 2'd1);
    check("resume.cnt", 192'(stall_cnt), 192'(CNT_EN ? 16'd3 : 16'd0));

    // Fill to FULL, then flush with a valid upstream beat present.
    up_data  = 32'd8;
    dn_ready = 1'b0;
    tick();
    check_main("prefl", 1'b1, 32'd7, 1'b0, 2'd2);
    up_data = 32'd9;
    flush   = 1'b1;
    tick();
    flush = 1'b0;
    check_main("flush", 1'b0, 32'd0, 1'b1, 2'd0);
    check("flush.cnt", 192'(stall_cnt), 192'(CNT_EN ? 16'd5 : 16'd0));
    up_data  = 32'd10;
    dn_ready = 1'b1;
    tick();
    check_main("postfl", 1'b1, 32'd10, 1'b1, 2'd1);

    // BUSY drains to EMPTY with no new input.
    up_valid = 1'b0;
    tick();
    check_main("drain", 1'b0, 32'd0, 1'b1, 2'd0);

    // Refill to FULL, then reset asynchronously between edges.
    up_valid = 1'b1;
    up_data  = 32'd11;
    dn_ready = 1'b0;
    tick();
    check_main("refill1", 1'b1, 32'd11, 1'b1, 2'd1);
    up_data = 32'd12;
    tick();
    check_main("refill2", 1'b1, 32'd11, 1'b0, 2'd2);
    check("refill.cnt", 192'(stall_cnt), 192'(CNT_EN ? 16'd6 : 16'd0));
    #2 rst = 1'b1;
    #1;
    check("arst.valid", 192'(dn_valid), 192'(1'b0));
    check("arst.data", 192'(dn_data), 192'(32'd0));
    check("arst.ready", 192'(up_ready), 192'(1'b1));
    check("arst.occ", 192'(occ), 192'(2'd0));
    check("arst.stall", 192'(stall_cnt), 192'(16'd0));
    #2 rst = 1'b0;
    up_data  = 32'd13;
    dn_ready = 1'b1;
    tick();
    check_main("postrst", 1'b1, 32'd13, 1'b1, 2'd1);
    up_valid = 1'b0;

    // Wide instance: one 143-bit beat held under a 6-edge stall; counter saturates.
    w_pat      = {15'h1234, {4{32'hdeadbeef}}};
    w_up_data  = w_pat;
    w_up_valid = 1'b1;
    w_dn_ready = 1'b0;
    tick();
    w_up_valid = 1'b0;
    check("wide.data", 192'(w_dn_data), 192'(w_pat));
    check("wide.cnt0", 192'(w_stall_cnt), 192'(2'd0));
    repeat (3) tick();
    check("wide.cnt3", 192'(w_stall_cnt), 192'(CNT_EN ? 2'd3 : 2'd0));
    repeat (3) tick();
    check("wide.sat", 192'(w_stall_cnt), 192'(CNT_EN ? 2'd3 : 2'd0));
    check("wide.hold", 192'(w_dn_data), 192'(w_pat));
    check("wide.occ", 192'(w_occ), 192'(2'd1));
    w_dn_ready = 1'b1;
    tick();
    check("wide.empty", 192'(w_dn_valid), 192'(1'b0));
    check("wide.ready", 192'(w_up_ready), 192'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised elastic pipeline register with a valid/ready handshake, a one-entry skid buffer, and synchronous flush. It replaces the fixed-width, always-enabled stage registers between IF/ID, ID/IS, IS/EX and EX/WB in the Core101 pipeline. This lets any stage stall or be flushed without combinational ready paths crossing stage boundaries. It sustains one transfer per cycle with one cycle of latency.

## Interface
- DATA_WIDTH, 32, payload width in bits (≥1); e.g. 64 for IF/ID, 143 for ID/IS.
- STALL_CNT_WIDTH, 16, width of the stall counter (≥1); used only with PIPE_SKID_STALL_CNT_EN.

- clock_in  input  1  single clock; all logic on rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- flush_in  input  1  synchronous flush; discards all held entries.
- up_valid_in  input  1  upstream offers up_data_in.
- up_data_in  input  DATA_WIDTH  upstream payload.
- up_ready_out  output  1  stage can accept; registered, no combinational path from dn_ready_in.
- dn_valid_out  output  1  dn_data_out is valid.
- dn_data_out  output  DATA_WIDTH  head payload; registered.
- dn_ready_in  input  1  downstream accepts this cycle.
- occupancy_out  output  2  entries held: 0, 1 or 2.
- stall_count_out  output  STALL_CNT_WIDTH  saturating count of downstream stall cycles.

## Operation
- A transfer happens on a clock edge when valid and ready are both high on that side.
- There are two storage registers: main (drives dn_data_out) and skid.
- States:
  - EMPTY: 0 entries.
  - BUSY: main valid.
  - FULL: main and skid valid.
- up_ready_out = (state != FULL). dn_valid_out = (state != EMPTY).
- Transitions, where in = upstream transfer and out = downstream transfer:
  - EMPTY: in → main←up_data_in, go to BUSY.
  - BUSY: in&out → main←up_data_in, stay BUSY.
  - BUSY: in&!out → skid←up_data_in, go to FULL.
  - BUSY: !in&out → go to EMPTY.
  - BUSY: neither → hold.
  - FULL: out → main←skid, go to BUSY. No upstream accept is possible in FULL.
  - FULL: !out → hold.
- Flush has highest priority. Next state is EMPTY, whatever the handshakes.
  - An upstream transfer in the flush cycle is discarded, even though up_ready_out was 1.
  - A downstream transfer in the flush cycle still counts as delivered; downstream owns it.
  - Data registers keep their contents, but they are not observable as valid.
- occupancy_out = 0/1/2 for EMPTY/BUSY/FULL.
- Payload is never reordered, duplicated or dropped except by flush.
- The payload is opaque: no arithmetic is done on it.

## Timing
- Reset values while reset_in is high (asynchronous):
  - state EMPTY, main and skid = 0.
  - dn_valid_out 0, dn_data_out 0, up_ready_out 1, occupancy_out 0, stall_count_out 0.
- Reset deassertion mid-operation: the first edge after release behaves as EMPTY. Any in-flight entries are lost.
- Latency: data accepted at edge N appears on dn_data_out with dn_valid_out=1 after edge N.
- Throughput: one transfer per cycle in steady state when dn_ready_in=1.
- Downstream stall: up_ready_out stays high for one cycle after dn_ready_in drops, and the skid register absorbs that beat. up_ready_out then falls at the following edge.
- After downstream resumes from FULL, up_ready_out rises one edge later.
- up_valid_in may be asserted regardless of up_ready_out. Upstream must hold its data until it is accepted.
- dn_valid_out never drops without a downstream transfer or a flush.

## Configuration
- PIPE_SKID_STALL_CNT_EN defined:
  - stall_count_out increments on each edge where dn_valid_out=1 and dn_ready_in=0.
  - It saturates at all-ones.
  - It is cleared only by reset_in, not by flush.
- PIPE_SKID_STALL_CNT_EN undefined:
  - The counter is not built.
  - stall_count_out is tied to 0, so the port list stays identical.

## Structure
- Shared package core101_pipe_pkg holds:
  - the state typedef (EMPTY=2'b00, BUSY=2'b01, FULL=2'b10);
  - occupancy constants.
- One sub-module: sat_counter (parameter WIDTH; ports clock_in, reset_in, inc_in, count_out). It is instantiated only under PIPE_SKID_STALL_CNT_EN.

## Test plan
- Streaming: DATA_WIDTH=32, up_valid_in=1 with data 1,2,3… and dn_ready_in=1 → dn_data_out 1,2,3… one cycle later, up_ready_out constantly 1, occupancy_out 1.
- Stall absorb: while streaming, drop dn_ready_in for 3 cycles → one extra beat captured in skid, occupancy_out=2, up_ready_out=0 from the next edge. On resume, the exact sequence continues with no loss or duplication. stall_count_out=3 with the macro, 0 without it.
- Flush: in FULL, pulse flush_in with up_valid_in=1 → next cycle dn_valid_out=0, occupancy_out=0, up_ready_out=1, and the flushed-cycle payload never appears downstream.
- Reset mid-operation: assert reset_in asynchronously between edges while FULL → outputs go immediately to dn_valid_out=0, dn_data_out=0, up_ready_out=1, occupancy_out=0.
- Randomised valid/ready with DATA_WIDTH=143 → scoreboard confirms in-order, lossless delivery and up_ready_out never depends combinationally on dn_ready_in.
- Saturation: STALL_CNT_WIDTH=2, hold downstream stalled for 6 cycles → stall_count_out reaches 3 and stays at 3.
